// File: rtl/stage_select_ctrl_if.sv
// Tap-to-output pixel bus for stage_select_ctrl.
// master drives the four taps, slave returns the selected pixel.
interface stage_select_ctrl_if;
  logic [11:0] tap0_data;
  logic [11:0] tap1_data;
  logic [11:0] tap2_data;
  logic [11:0] tap3_data;
  logic        tap0_ready;
  logic        tap1_ready;
  logic        tap2_ready;
  logic        tap3_ready;
  logic [11:0] pixel_out;
  logic        out_ready;

  modport master (
    output tap0_data, tap1_data,
    output tap2_data, tap3_data,
    output tap0_ready, tap1_ready,
    output tap2_ready, tap3_ready,
    input  pixel_out, out_ready
  );

  modport slave (
    input  tap0_data, tap1_data,
    input  tap2_data, tap3_data,
    input  tap0_ready, tap1_ready,
    input  tap2_ready, tap3_ready,
    output pixel_out, out_ready
  );
endinterface

// File: rtl/stage_select_ctrl.sv
// Push-button pipeline tap selector, switching only on frame boundaries.
// Optional frame watchdog: define STAGE_SEL_WATCHDOG_EN.
module stage_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WD_CYCLES       = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  input  logic              frame_start,
  stage_select_ctrl_if.slave px,
  output logic [1:0]        mode,
  output logic              mode_pending,
  output logic              frame_lost
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [1:0]     sync_q, sync_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_q, db_d;
  logic           press_q, press_d;
  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [1:0]     next_q, next_d;
  logic [11:0]    pix_q, pix_d;
  logic           ordy_q, ordy_d;
  logic           lost_w;
  logic           commit;
  logic [1:0]     sel;
  logic           tap_rdy;
  logic [11:0]    tap_dat;

  always_comb begin
    sync_d   = {sync_q[0], key_n};
    db_d     = db_q;
    db_cnt_d = '0;
    // counter only runs while the synced level disagrees
    if (sync_q[1] != db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = db_q & ~db_d;
  end

  assign commit = (state_q == PENDING)
                & (frame_start | lost_w);
  assign sel    = commit ? next_q : mode_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    next_d  = next_q;
    unique case (state_q)
      RUN: begin
        if (press_q) begin
          next_d  = mode_q + 2'd1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (commit) begin
          mode_d  = next_q;
          state_d = press_q ? PENDING : RUN;
        end
        if (press_q) begin
          next_d = next_q + 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    tap_rdy = 1'b0;
    tap_dat = '0;
    unique case (sel)
      2'd0: begin
        tap_rdy = px.tap0_ready;
        tap_dat = px.tap0_data;
      end
      2'd1: begin
        tap_rdy = px.tap1_ready;
        tap_dat = px.tap1_data;
      end
      2'd2: begin
        tap_rdy = px.tap2_ready;
        tap_dat = px.tap2_data;
      end
      2'd3: begin
        tap_rdy = px.tap3_ready;
        tap_dat = px.tap3_data;
      end
      default: begin
        tap_rdy = 1'b0;
        tap_dat = '0;
      end
    endcase
    ordy_d = tap_rdy;
    pix_d  = tap_rdy ? tap_dat : pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      db_cnt_q <= '0;
      db_q     <= 1'b1;
      press_q  <= 1'b0;
      state_q  <= RUN;
      mode_q   <= 2'd0;
      next_q   <= 2'd0;
      pix_q    <= '0;
      ordy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      db_q     <= db_d;
      press_q  <= press_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      next_q   <= next_d;
      pix_q    <= pix_d;
      ordy_q   <= ordy_d;
    end
  end

`ifdef STAGE_SEL_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           lost_q, lost_d;

  always_comb begin
    if (frame_start) begin
      wd_d   = '0;
      lost_d = 1'b0;
    end else begin
      wd_d   = (wd_q == WDW'(WD_CYCLES))
             ? wd_q : wd_q + 1'b1;
      lost_d = lost_q | (wd_d == WDW'(WD_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      lost_q <= lost_d;
    end
  end

  assign lost_w = lost_q;
`else
  assign lost_w = 1'b0 && (WD_CYCLES > 0);
`endif

  assign mode         = mode_q;
  assign mode_pending = (state_q == PENDING);
  assign frame_lost   = lost_w;
  assign px.pixel_out = pix_q;
  assign px.out_ready = ordy_q;

endmodule

// File: tb/tb_stage_select_ctrl.sv
// Randomized bench for stage_select_ctrl against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_stage_select_ctrl;
  localparam int D  = 4;
  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [11:0] td[4] = '{default: 12'h000};
  logic        tr[4] = '{default: 1'b0};
  logic [1:0]  mode;
  logic        mode_pending;
  logic        frame_lost;

  int checks = 0;
  int failures = 0;

  stage_select_ctrl_if sif ();

  assign sif.tap0_data  = td[0];
  assign sif.tap1_data  = td[1];
  assign sif.tap2_data  = td[2];
  assign sif.tap3_data  = td[3];
  assign sif.tap0_ready = tr[0];
  assign sif.tap1_ready = tr[1];
  assign sif.tap2_ready = tr[2];
  assign sif.tap3_ready = tr[3];

  stage_select_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .WD_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .frame_start(frame_start),
    .px(sif),
    .mode(mode),
    .mode_pending(mode_pending),
    .frame_lost(frame_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // behavioural model: history of raw key samples, plain integers
  bit          kh[$];
  bit          m_level;
  bit          m_press;
  int          m_mode;
  int          m_next;
  bit          m_pend;
  int          m_wd;
  bit          m_lost;
  logic [11:0] m_pix;
  bit          m_ordy;
  bit          started = 1'b0;
  bit          commit;
  bit          all_diff;
  bit          evt;
  int          sel;

  always @(posedge clk) begin
    if (rst) begin
      kh = {};
      repeat (D + 2) kh.push_back(1'b1);
      m_level = 1'b1;
      m_press = 1'b0;
      m_mode  = 0;
      m_next  = 0;
      m_pend  = 1'b0;
      m_wd    = 0;
      m_lost  = 1'b0;
      m_pix   = 12'h000;
      m_ordy  = 1'b0;
    end else begin
      commit = m_pend && (frame_start || m_lost);
      sel    = commit ? m_next : m_mode;
      m_ordy = tr[sel];
      if (tr[sel]) m_pix = td[sel];
      if (m_pend) begin
        if (commit) begin
          m_mode = m_next;
          m_pend = m_press;
        end
        if (m_press) m_next = (m_next + 1) % 4;
      end else if (m_press) begin
        m_next = (m_mode + 1) % 4;
        m_pend = 1'b1;
      end
`ifdef STAGE_SEL_WATCHDOG_EN
      if (frame_start) begin
        m_wd   = 0;
        m_lost = 1'b0;
      end else begin
        if (m_wd < WD) m_wd++;
        if (m_wd == WD) m_lost = 1'b1;
      end
`endif
      // level flips once D synchronized samples all disagree
      all_diff = 1'b1;
      for (int i = 1; i <= D; i++)
        if (kh[i] == m_level) all_diff = 1'b0;
      evt = 1'b0;
      if (all_diff) begin
        evt     = m_level;
        m_level = ~m_level;
      end
      m_press = evt;
      kh.push_front(key_n);
      void'(kh.pop_back());
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mode", 32'(mode), 32'(m_mode));
      chk("pending", 32'(mode_pending), 32'(m_pend));
      chk("out_ready", 32'(sif.out_ready), 32'(m_ordy));
      chk("pixel_out", 32'(sif.pixel_out), 32'(m_pix));
      chk("frame_lost", 32'(frame_lost), 32'(m_lost));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic press();
    key_n = 1'b0;
    cyc(4);
    key_n = 1'b1;
    cyc(4);
  endtask

  int run_len = 0;

  initial begin
    rst = 1'b1;
    cyc(3);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_pending", 32'(mode_pending), 0);
    chk("rst_out_ready", 32'(sif.out_ready), 0);
    chk("rst_pixel", 32'(sif.pixel_out), 0);
    chk("rst_lost", 32'(frame_lost), 0);
    rst = 1'b0;

    key_n = 1'b0;
    cyc(2);
    key_n = 1'b1;
    cyc(8);
    chk("glitch_mode", 32'(mode), 0);
    chk("glitch_pending", 32'(mode_pending), 0);
    chk("model_glitch_pend", 32'(m_pend), 0);

`ifndef STAGE_SEL_WATCHDOG_EN
    press();
    chk("wrap_pending", 32'(mode_pending), 1);
    press();
    press();
    press();
    chk("wrap_mode_hold", 32'(mode), 0);
    fs_pulse();
    chk("wrap_mode", 32'(mode), 0);
    chk("wrap_pending_clr", 32'(mode_pending), 0);
`endif

    fs_pulse();
    press();
    chk("mid_pend", 32'(mode_pending), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rstpend_mode", 32'(mode), 0);
    chk("rstpend_pending", 32'(mode_pending), 0);
    cyc(2);
    fs_pulse();

    key_n = 1'b0;
    cyc(10);
    key_n = 1'b1;
    chk("hold_pending", 32'(mode_pending), 1);
    chk("hold_mode", 32'(mode), 0);
    td[0] = 12'h555;
    tr[0] = 1'b1;
    td[1] = 12'h123;
    tr[1] = 1'b1;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    tr[0] = 1'b0;
    tr[1] = 1'b0;
    chk("fs_mode", 32'(mode), 1);
    chk("fs_pending", 32'(mode_pending), 0);
    chk("fs_pixel", 32'(sif.pixel_out), 32'h123);
    chk("fs_ready", 32'(sif.out_ready), 1);
    chk("model_fs_mode", 32'(m_mode), 1);
    cyc(6);

    fs_pulse();
    key_n = 1'b0;
    cyc(4);
    key_n = 1'b1;
    cyc(4);
    chk("co_pre_pending", 32'(mode_pending), 1);
    chk("co_pre_mode", 32'(mode), 1);
    key_n = 1'b0;
    cyc(4);
    key_n = 1'b1;
    cyc(2);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("co_mode", 32'(mode), 2);
    chk("co_pending", 32'(mode_pending), 1);
    chk("model_co_next", 32'(m_next), 3);

    td[2] = 12'hABC;
    tr[2] = 1'b1;
    cyc(1);
    tr[2] = 1'b0;
    td[2] = 12'h000;
    chk("t2_ready", 32'(sif.out_ready), 1);
    chk("t2_pixel", 32'(sif.pixel_out), 32'hABC);
    cyc(1);
    chk("t2_ready_low", 32'(sif.out_ready), 0);
    chk("t2_pixel_held", 32'(sif.pixel_out), 32'hABC);
    chk("t2_mode", 32'(mode), 2);
    cyc(2);
    fs_pulse();
    chk("next_commit_mode", 32'(mode), 3);
    chk("next_commit_pend", 32'(mode_pending), 0);

    press();
    cyc(12);
`ifdef STAGE_SEL_WATCHDOG_EN
    chk("wd_lost", 32'(frame_lost), 1);
    chk("wd_mode", 32'(mode), 0);
    chk("wd_pending", 32'(mode_pending), 0);
`else
    chk("wd_lost", 32'(frame_lost), 0);
    chk("wd_mode", 32'(mode), 3);
    chk("wd_pending", 32'(mode_pending), 1);
`endif
    fs_pulse();
    chk("wd_lost_clr", 32'(frame_lost), 0);
    chk("wd_mode_after", 32'(mode), 0);
    chk("wd_pend_after", 32'(mode_pending), 0);

    for (int n = 0; n < 4000; n++) begin
      if (run_len == 0) begin
        key_n   = 1'($urandom_range(0, 1));
        run_len = $urandom_range(1, 10);
      end
      run_len--;
      frame_start = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int t = 0; t < 4; t++) begin
        td[t] = 12'($urandom);
        tr[t] = 1'($urandom_range(0, 1));
      end
      cyc(1);
    end
    rst = 1'b0;
    frame_start = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/stage_select_ctrl.md
STAGE_SELECT_CTRL -- requirements
Module: stage_select_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, the cycles key_n must hold stable before a level change is accepted (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter WD_CYCLES, default 1000000, the cycles without frame_start before the frame is declared lost.
REQ-003 The block SHALL have port clk  in  1  video clock; the single clock for all logic.
REQ-004 The block SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port key_n  in  1  raw push-button, active-low, asynchronous to clk.
REQ-006 The block SHALL have port frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-007 The block SHALL have ports tapN_data  in  12  pixel from pipeline tap N, N=0..3: 0 raw RGB, 1 grey, 2 gaussian, 3 edge.
REQ-008 The block SHALL have ports tapN_ready  in  1  valid strobe for tapN_data, N=0..3.
REQ-009 The block SHALL have port pixel_out  out  12  selected tap pixel, registered.
REQ-010 The block SHALL have port out_ready  out  1  valid strobe aligned with pixel_out.
REQ-011 The block SHALL have port mode  out  2  tap currently driving the output.
REQ-012 The block SHALL have port mode_pending  out  1  high while a mode change waits for a frame boundary.
REQ-013 The block SHALL have port frame_lost  out  1  watchdog flag.

Function
REQ-014 The block SHALL pass key_n through a 2-flop synchronizer before any other use.
REQ-015 The debouncer SHALL reload its counter on every synchronized change and SHALL update the debounced level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; a release SHALL generate no event.
REQ-017 The FSM SHALL have two states, RUN and PENDING, and mode_pending SHALL be 1 exactly in PENDING.
REQ-018 On a press in RUN, the block SHALL set next_mode = mode+1 mod 4 and enter PENDING.
REQ-019 On a press in PENDING, the block SHALL set next_mode = next_mode+1 mod 4 (wrap 3->0) and remain in PENDING.
REQ-020 On frame_start in PENDING, the block SHALL load mode from next_mode and return to RUN; mode SHALL never change at any other time except per REQ-027.
REQ-021 The selection used for frame_start's own cycle SHALL be the effective mode, (PENDING && frame_start) ? next_mode : mode, so the whole new frame uses the new tap.
REQ-022 When press and frame_start coincide in PENDING, the block SHALL commit the old next_mode first, then re-enter PENDING with that committed value +1.
REQ-023 When press and frame_start coincide in RUN, the block SHALL enter PENDING and leave mode unchanged until the next frame_start.
REQ-024 The block SHALL register pixel_out and out_ready one cycle after the selected tap's inputs (latency 1), and out_ready SHALL equal the selected tap's ready delayed by one cycle.
REQ-025 When out_ready=0, pixel_out SHALL hold its previous value.

Reset
REQ-026 While rst=1, at the clock edge the block SHALL set mode=0, next_mode=0, state=RUN, pixel_out=0, out_ready=0, frame_lost=0, clear all counters, and set the synchronizer and debounced level to 1 (released); on reset mid-PENDING the pending change SHALL be discarded.

Configuration
REQ-027 With STAGE_SEL_WATCHDOG_EN defined, the block SHALL count cycles since the last frame_start, saturating, and at count == WD_CYCLES SHALL set frame_lost=1 and hold it until the next frame_start clears it and the count; while frame_lost=1, PENDING SHALL commit on its next cycle without waiting for frame_start.
REQ-028 Without STAGE_SEL_WATCHDOG_EN, the block SHALL tie frame_lost to 0, instantiate no watchdog counter, and commit only on frame_start.

Verification (DEBOUNCE_CYCLES=4, WD_CYCLES=16)
REQ-029 The bench SHALL drive a 2-cycle low glitch on key_n -> no press event; mode=0, mode_pending=0.
REQ-030 The bench SHALL hold key_n low 10 cycles, then pulse frame_start -> mode_pending=1 until frame_start; mode=1 from that cycle; pixel_out=tap1_data one cycle later.
REQ-031 The bench SHALL make 4 presses before any frame_start -> next_mode wraps 1,2,3,0; at frame_start mode=0 and mode_pending=0.
REQ-032 The bench SHALL make a press coincident with frame_start while PENDING with next_mode=2 -> mode=2, mode_pending=1, next_mode=3.
REQ-033 The bench SHALL drive tap2_ready=1 for 1 cycle with data 0xABC while mode=2 -> out_ready=1 and pixel_out=0xABC next cycle, then out_ready=0 and pixel_out held at 0xABC.
REQ-034 With the macro defined, the bench SHALL press and then send no frame_start for 16 cycles -> frame_lost=1, mode commits next cycle; a subsequent frame_start clears frame_lost; without the macro, frame_lost stays 0 and mode stays unchanged.
